// File: rtl/bist_march_sequencer_pkg.sv
// Shared March C- definitions: element/op/state enums and the per-element
// tables (direction, op count, op types, pattern bits) the sequencer walks.
package bist_pkg;

    typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;
    typedef enum logic       {OP_W, OP_R}             op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE}        state_t;

    // Tables are indexed by elem_t; bit n describes element Mn.
    localparam logic [7:0] ELEM_DOWN    = 8'b0011_1000; // M3..M5 walk N-1..0
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110; // M1..M4 have two ops
    localparam logic [7:0] OP0_IS_WR    = 8'b0000_0001; // only M0 starts with a write
    localparam logic [7:0] OP0_PAT      = 8'b0001_0100; // M2 r1, M4 r1
    localparam logic [7:0] OP1_PAT      = 8'b0000_1010; // M1 w1, M3 w1

    // Second op of a two-op element is always a write.
    function automatic op_t op_type(input elem_t e, input logic op);
        return (op || OP0_IS_WR[e]) ? OP_W : OP_R;
    endfunction

    function automatic logic pat_bit(input elem_t e, input logic op);
        return op ? OP1_PAT[e] : OP0_PAT[e];
    endfunction

endpackage

// File: rtl/bist_march_sequencer_if.sv
// Sequencer bus: controller handshake (ld/NbarT/cout) plus memory op outputs.
interface bist_march_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ld;
    logic              NbarT;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_data;
    logic              we;
    logic              re;
    logic              cout;

    modport master (output ld, NbarT, input addr, wdata, exp_data, we, re, cout);
    modport slave  (input ld, NbarT, output addr, wdata, exp_data, we, re, cout);
endinterface

// File: rtl/bist_march_sequencer_addr_counter.sv
// Up/down address counter with load, enable and terminal-count flag.
module bist_addr_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         down,
    output logic [W-1:0] cnt,
    output logic         tc
);
    localparam logic [W-1:0] ONE = W'(1);

    // Load wins over counting; count direction follows the current element.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en)   cnt <= down ? cnt - ONE : cnt + ONE;
    end

    assign tc = down ? (cnt == '0) : (cnt == '1);
endmodule

// File: rtl/bist_march_sequencer.sv
// March C- sequencer: one memory operation per test-mode clock, 10N ops.
// Optional BIST_DATA_BACKGROUND_EN selects a checkerboard data background
// instead of solid zeros/ones; sequence timing is identical in both builds.
module bist_march_sequencer
    import bist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    bist_march_sequencer_if.slave bus
);
    state_t            state, state_n;
    elem_t             elem, elem_n;
    logic              op, op_n;
    logic              cout_q, done_pulse;
    logic              cnt_load, cnt_en, cnt_tc;
    logic [ADDR_W-1:0] cnt, cnt_load_val;
    logic [DATA_W-1:0] pat_word;
    op_t               cur_type;

    bist_addr_counter #(.W(ADDR_W)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .down     (ELEM_DOWN[elem]),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    // Sequence position registers plus the registered completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            elem   <= M0;
            op     <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            state  <= state_n;
            elem   <= elem_n;
            op     <= op_n;
            cout_q <= done_pulse;
        end
    end

    // Advance order: op within element, then address, then element.
    always_comb begin
        elem_t nxt;
        state_n      = state;
        elem_n       = elem;
        op_n         = op;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        done_pulse   = 1'b0;
        nxt          = elem_t'(elem + 3'd1);
        if (bus.ld) begin
            state_n  = RUN;
            elem_n   = M0;
            op_n     = 1'b0;
            cnt_load = 1'b1;
        end else if (state == RUN && bus.NbarT) begin
            if (!op && ELEM_TWO_OPS[elem]) begin
                op_n = 1'b1;
            end else begin
                op_n = 1'b0;
                if (!cnt_tc) begin
                    cnt_en = 1'b1;
                end else if (elem == M5) begin
                    // Final op lands on addr 0, so the counter already rests there.
                    state_n    = DONE;
                    done_pulse = 1'b1;
                end else begin
                    elem_n       = nxt;
                    cnt_load     = 1'b1;
                    cnt_load_val = ELEM_DOWN[nxt] ? '1 : '0;
                end
            end
        end
    end

    // Data background: pattern bit selects the word or its complement.
`ifdef BIST_DATA_BACKGROUND_EN
    assign pat_word = {(DATA_W/2){2'b01}} ^ {DATA_W{cnt[0]}} ^ {DATA_W{pat_bit(elem, op)}};
`else
    assign pat_word = {DATA_W{pat_bit(elem, op)}};
`endif

    assign cur_type = op_type(elem, op);

    // Memory op outputs decoded from state; strobes only while advancing.
    always_comb begin
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.exp_data = '0;
        bus.we       = 1'b0;
        bus.re       = 1'b0;
        if (state == RUN) begin
            bus.addr = cnt;
            if (bus.NbarT) begin
                if (cur_type == OP_W) begin
                    bus.we    = 1'b1;
                    bus.wdata = pat_word;
                end else begin
                    bus.re       = 1'b1;
                    bus.exp_data = pat_word;
                end
            end
        end
    end

    assign bus.cout = cout_q;
endmodule

// File: tb/tb_bist_march_sequencer.sv
// Bench for bist_march_sequencer: op-list model of March C- checked every
// cycle, plus directed literal checks at element boundaries, pause, reset,
// and ld coinciding with completion. Honours BIST_DATA_BACKGROUND_EN.
module tb_bist_march_sequencer;
    localparam int AW   = 6;
    localparam int DW   = 8;
    localparam int N    = 1 << AW;
    localparam int NOPS = 10 * N;

`ifdef BIST_DATA_BACKGROUND_EN
    localparam logic [7:0] P0A0 = 8'h55, P0A1 = 8'hAA, P1A0 = 8'hAA;
`else
    localparam logic [7:0] P0A0 = 8'h00, P0A1 = 8'h00, P1A0 = 8'hFF;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bist_march_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    bist_march_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Expected op list, built from the algorithm description.
    logic [AW-1:0] t_addr [NOPS];
    bit            t_wr   [NOPS];
    bit            t_pat  [NOPS];
    int            nt;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic push(input int a, input bit w, input bit p);
        t_addr[nt] = AW'(a);
        t_wr[nt]   = w;
        t_pat[nt]  = p;
        nt++;
    endtask

    task automatic build();
        nt = 0;
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < N; i++) begin
                int a;
                a = (e >= 3) ? N - 1 - i : i;
                case (e)
                    0: push(a, 1, 0);
                    1: begin push(a, 0, 0); push(a, 1, 1); end
                    2: begin push(a, 0, 1); push(a, 1, 0); end
                    3: begin push(a, 0, 0); push(a, 1, 1); end
                    4: begin push(a, 0, 1); push(a, 1, 0); end
                    default: push(a, 0, 0);
                endcase
            end
    endtask

    function automatic logic [DW-1:0] word(input bit p, input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int b = 0; b < DW; b++) begin
`ifdef BIST_DATA_BACKGROUND_EN
            w[b] = p ^ a[0] ^ ((b % 2) == 0);
`else
            w[b] = p;
`endif
        end
        return w;
    endfunction

    // Model state: running flag, op index since load, expected cout.
    bit m_run  = 1'b0;
    int m_k    = 0;
    bit m_cout = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_k    <= 0;
            m_cout <= 1'b0;
        end else begin
            m_cout <= 1'b0;
            if (bus.ld) begin
                m_run <= 1'b1;
                m_k   <= 0;
            end else if (m_run && bus.NbarT) begin
                if (m_k == NOPS - 1) begin
                    m_run  <= 1'b0;
                    m_cout <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cmp_cycle();
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, ee;
        bit            ewe, ere;
        ea = '0; ew = '0; ee = '0; ewe = 1'b0; ere = 1'b0;
        if (m_run) begin
            ea = t_addr[m_k];
            if (bus.NbarT) begin
                if (t_wr[m_k]) begin ewe = 1'b1; ew = word(t_pat[m_k], ea); end
                else           begin ere = 1'b1; ee = word(t_pat[m_k], ea); end
            end
        end
        chk("cycle", {bus.addr, bus.wdata, bus.exp_data, bus.we, bus.re, bus.cout},
                     {ea, ew, ee, ewe, ere, m_cout});
    endtask

    // Each cycle: compare against the model at negedge, return at posedge+1.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cmp_cycle();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int cpulse;
        build();
        bus.ld = 1'b0;
        bus.NbarT = 1'b0;
        step(2);
        #1;
        chk("reset addr", bus.addr, 0);
        chk("reset strobes/cout", {bus.we, bus.re, bus.cout}, 0);
        chk("reset data", {bus.wdata, bus.exp_data}, 0);
        rst = 1'b0;
        step(2);

        // Full run with element boundaries.
        bus.ld = 1'b1; bus.NbarT = 1'b1;
        step(1);
        bus.ld = 1'b0;
        #1;
        chk("op0 addr", bus.addr, 0);
        chk("op0 we", {bus.we, bus.re}, 2'b10);
        chk("op0 wdata", bus.wdata, P0A0);
        step(1); #1;
        chk("op1 addr", bus.addr, 1);
        chk("op1 wdata", bus.wdata, P0A1);
        step(63); #1;
        chk("op64 addr", bus.addr, 0);
        chk("op64 re", {bus.we, bus.re}, 2'b01);
        chk("op64 exp", bus.exp_data, P0A0);
        step(1); #1;
        chk("op65 addr", bus.addr, 0);
        chk("op65 wdata", {bus.we, bus.wdata}, {1'b1, P1A0});
        step(255); #1;
        chk("op320 addr", bus.addr, 63);
        chk("op320 re", {bus.we, bus.re}, 2'b01);
        chk("op320 exp", bus.exp_data, P0A1);
        step(319); #1;
        chk("cycle639 cout", bus.cout, 0);
        step(1); #1;
        chk("cycle640 cout", bus.cout, 1);
        chk("done addr", bus.addr, 0);
        step(1); #1;
        chk("cycle641 cout", bus.cout, 0);

        // Pause at op 100 (M1 r0, addr 18) for five cycles.
        bus.ld = 1'b1;
        step(1);
        bus.ld = 1'b0;
        step(100);
        bus.NbarT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("pause", {bus.addr, bus.we, bus.re}, {6'd18, 2'b00});
            step(1);
        end
        bus.NbarT = 1'b1;
        #1;
        chk("resume op100", {bus.addr, bus.we, bus.re}, {6'd18, 2'b01});
        step(539); #1;
        chk("pause cycle644 cout", bus.cout, 0);
        step(1); #1;
        chk("pause cycle645 cout", bus.cout, 1);
        step(1);

        // Asynchronous reset mid-run at op 300.
        bus.ld = 1'b1;
        step(1);
        bus.ld = 1'b0;
        step(300);
        #1 rst = 1'b1;
        #1;
        chk("async reset outputs",
            {bus.addr, bus.wdata, bus.exp_data, bus.we, bus.re, bus.cout}, 0);
        step(3);
        rst = 1'b0;
        cpulse = 0;
        for (int i = 0; i < 700; i++) begin
            step(1);
            if (bus.cout) cpulse++;
        end
        chk("no cout after reset", cpulse, 0);
        bus.ld = 1'b1;
        step(1);
        bus.ld = 1'b0;
        step(640); #1;
        chk("restart cout", bus.cout, 1);
        step(2);

        // ld coincident with final op.
        bus.ld = 1'b1;
        step(1);
        bus.ld = 1'b0;
        step(639); #1;
        chk("op639", {bus.addr, bus.we, bus.re}, {6'd0, 2'b01});
        bus.ld = 1'b1;
        step(1);
        bus.ld = 1'b0;
        #1;
        chk("ld@final cout", bus.cout, 0);
        chk("ld@final op0", {bus.addr, bus.we, bus.re, bus.wdata}, {6'd0, 2'b10, P0A0});
        step(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
